// File: rtl/ram_rw_master_pkg.sv
// Shared types and helpers for the RAM read/write master: FSM states, access sizes,
// byte-mask table and alignment check.
package ram_rw_master_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2
   } state_e;

   localparam logic [1:0] SizeByte  = 2'd0;
   localparam logic [1:0] SizeHalf  = 2'd1;
   localparam logic [1:0] SizeWord  = 2'd2;
   localparam logic [1:0] SizeDword = 2'd3;

   // Fetches always go out to the RAM as 32-bit reads.
   localparam logic [2:0] FetchRamSize = 3'd2;

   localparam logic GrantFetch = 1'b0;
   localparam logic GrantData  = 1'b1;

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      logic [7:0] mask;
      case (size)
         SizeByte: mask = 8'h01;
         SizeHalf: mask = 8'h03;
         SizeWord: mask = 8'h0F;
         default:  mask = 8'hFF;
      endcase
      return mask;
   endfunction

   function automatic logic misaligned(input logic [2:0] offset, input logic [1:0] size);
      logic bad;
      case (size)
         SizeByte: bad = 1'b0;
         SizeHalf: bad = offset[0];
         SizeWord: bad = |offset[1:0];
         default:  bad = |offset;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Combinational lane steering: shifts store data/mask into byte lanes and extracts,
// truncates and sign/zero-extends load data.
module ram_lane_align
   import ram_rw_master_pkg::*;
(
   input  logic [2:0]  offset,
   input  logic [1:0]  size,
   input  logic        we,
   input  logic        is_unsigned,
   input  logic [63:0] st_data,
   input  logic [63:0] ld_raw,
   output logic [63:0] st_wdata,
   output logic [7:0]  st_wmask,
   output logic [63:0] ld_data
);

   logic [5:0]  shamt;
   logic [63:0] ld_shifted;

   assign shamt = {offset, 3'b000};

   always_comb begin
      st_wdata   = st_data << shamt;
      st_wmask   = we ? (size_mask(size) << offset) : 8'h00;
      ld_shifted = ld_raw >> shamt;
      ld_data    = ld_shifted;
      case (size)
         SizeByte: ld_data = is_unsigned ? {56'd0, ld_shifted[7:0]}
                                         : {{56{ld_shifted[7]}}, ld_shifted[7:0]};
         SizeHalf: ld_data = is_unsigned ? {48'd0, ld_shifted[15:0]}
                                         : {{48{ld_shifted[15]}}, ld_shifted[15:0]};
         SizeWord: ld_data = is_unsigned ? {32'd0, ld_shifted[31:0]}
                                         : {{32{ld_shifted[31]}}, ld_shifted[31:0]};
         default:  ld_data = ld_shifted;
      endcase
   end

endmodule

// File: rtl/ram_rw_master.sv
// Arbitrates an instruction-fetch port and a load/store port onto a single RAM
// read/write channel, one outstanding transaction at a time.
module ram_rw_master
   import ram_rw_master_pkg::*;
#(
   parameter int unsigned RR_ARB = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [63:0] if_addr,
   output logic        if_rsp_valid,
   output logic [31:0] if_instr,
   output logic        if_err,
   input  logic        ls_req_valid,
   output logic        ls_req_ready,
   input  logic        ls_we,
   input  logic [63:0] ls_addr,
   input  logic [1:0]  ls_size,
   input  logic        ls_unsigned,
   input  logic [63:0] ls_wdata,
   output logic        ls_rsp_valid,
   output logic [63:0] ls_rdata,
   output logic        ls_err,
   output logic        ram_rw_cen_o,
   output logic        ram_rw_wen_o,
   output logic [63:0] ram_rw_addr_o,
   output logic [63:0] ram_rw_wdata_o,
   output logic [7:0]  ram_rw_wmask_o,
   output logic [2:0]  ram_rw_size_o,
   input  logic        ram_rw_ready_i,
   input  logic [63:0] ram_rw_data_i
);

   state_e      state_q, state_d;
   logic        grant_q, grant_d;
   logic        we_q, we_d;
   logic [63:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [63:0] wdata_q, wdata_d;
   logic        fetch_q, fetch_d;

   logic        if_rsp_valid_q, if_rsp_valid_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic        if_err_q, if_err_d;
   logic        ls_rsp_valid_q, ls_rsp_valid_d;
   logic [63:0] ls_rdata_q, ls_rdata_d;
   logic        ls_err_q, ls_err_d;

   logic        idle, issue, ls_pref, choose_ls, ls_accept, if_accept;
   logic [63:0] st_wdata, ld_data;
   logic [7:0]  st_wmask;

   assign idle  = (state_q == StIdle) && !reset;
   assign issue = (state_q == StIssue) && !reset;

   // The data port keeps priority unless round-robin is on and it won last time.
   assign ls_pref   = (RR_ARB == 0) || (grant_q == GrantFetch);
   assign choose_ls = if_req_valid ? (ls_req_valid && ls_pref) : 1'b1;

   assign ls_req_ready = idle && choose_ls;
   assign if_req_ready = idle && !choose_ls;
   assign ls_accept    = ls_req_valid && ls_req_ready;
   assign if_accept    = if_req_valid && if_req_ready;

   ram_lane_align u_align (
      .offset      (addr_q[2:0]),
      .size        (size_q),
      .we          (we_q),
      .is_unsigned (uns_q),
      .st_data     (wdata_q),
      .ld_raw      (ram_rw_data_i),
      .st_wdata    (st_wdata),
      .st_wmask    (st_wmask),
      .ld_data     (ld_data)
   );

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      we_d           = we_q;
      addr_d         = addr_q;
      size_d         = size_q;
      uns_d          = uns_q;
      wdata_d        = wdata_q;
      fetch_d        = fetch_q;
      if_rsp_valid_d = 1'b0;
      if_instr_d     = if_instr_q;
      if_err_d       = if_err_q;
      ls_rsp_valid_d = 1'b0;
      ls_rdata_d     = ls_rdata_q;
      ls_err_d       = ls_err_q;
      case (state_q)
         StIdle: begin
            if (ls_accept) begin
               grant_d = GrantData;
               if (misaligned(ls_addr[2:0], ls_size)) begin
                  ls_rsp_valid_d = 1'b1;
                  ls_err_d       = 1'b1;
                  ls_rdata_d     = '0;
               end else begin
                  we_d    = ls_we;
                  addr_d  = ls_addr;
                  size_d  = ls_size;
                  uns_d   = ls_unsigned;
                  wdata_d = ls_wdata;
                  fetch_d = 1'b0;
                  state_d = StIssue;
               end
            end else if (if_accept) begin
               grant_d = GrantFetch;
               if (misaligned(if_addr[2:0], SizeWord)) begin
                  if_rsp_valid_d = 1'b1;
                  if_err_d       = 1'b1;
                  if_instr_d     = '0;
               end else begin
                  we_d    = 1'b0;
                  addr_d  = if_addr;
                  size_d  = SizeWord;
                  uns_d   = 1'b0;
                  wdata_d = '0;
                  fetch_d = 1'b1;
                  state_d = StIssue;
               end
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (ram_rw_ready_i) begin
               state_d = StIdle;
               if (fetch_q) begin
                  if_rsp_valid_d = 1'b1;
                  if_err_d       = 1'b0;
                  if_instr_d     = addr_q[2] ? ram_rw_data_i[63:32] : ram_rw_data_i[31:0];
               end else begin
                  ls_rsp_valid_d = 1'b1;
                  ls_err_d       = 1'b0;
                  ls_rdata_d     = we_q ? 64'd0 : ld_data;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= StIdle;
         grant_q        <= GrantData;
         we_q           <= 1'b0;
         addr_q         <= '0;
         size_q         <= '0;
         uns_q          <= 1'b0;
         wdata_q        <= '0;
         fetch_q        <= 1'b0;
         if_rsp_valid_q <= 1'b0;
         if_instr_q     <= '0;
         if_err_q       <= 1'b0;
         ls_rsp_valid_q <= 1'b0;
         ls_rdata_q     <= '0;
         ls_err_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         we_q           <= we_d;
         addr_q         <= addr_d;
         size_q         <= size_d;
         uns_q          <= uns_d;
         wdata_q        <= wdata_d;
         fetch_q        <= fetch_d;
         if_rsp_valid_q <= if_rsp_valid_d;
         if_instr_q     <= if_instr_d;
         if_err_q       <= if_err_d;
         ls_rsp_valid_q <= ls_rsp_valid_d;
         ls_rdata_q     <= ls_rdata_d;
         ls_err_q       <= ls_err_d;
      end
   end

   // Outputs are forced low while reset is held, before the registers have cleared.
   assign if_rsp_valid   = if_rsp_valid_q && !reset;
   assign if_instr       = reset ? 32'd0 : if_instr_q;
   assign if_err         = if_err_q && !reset;
   assign ls_rsp_valid   = ls_rsp_valid_q && !reset;
   assign ls_rdata       = reset ? 64'd0 : ls_rdata_q;
   assign ls_err         = ls_err_q && !reset;
   assign ram_rw_cen_o   = issue;
   assign ram_rw_wen_o   = issue && we_q;
   assign ram_rw_addr_o  = issue ? addr_q : 64'd0;
   assign ram_rw_wdata_o = issue ? st_wdata : 64'd0;
   assign ram_rw_wmask_o = issue ? st_wmask : 8'h00;
   assign ram_rw_size_o  = !issue ? 3'd0 : (fetch_q ? FetchRamSize : {1'b0, size_q});

endmodule

// File: tb/tb_ram_rw_master.sv
// Scoreboard bench for ram_rw_master: directed requests push expected RAM accesses and
// responses; a negedge monitor pops and compares them.
module tb_ram_rw_master;

   logic        clock, reset;
   logic        if_req_valid, if_req_ready, if_rsp_valid, if_err;
   logic [63:0] if_addr;
   logic [31:0] if_instr;
   logic        ls_req_valid, ls_req_ready, ls_we, ls_unsigned, ls_rsp_valid, ls_err;
   logic [63:0] ls_addr, ls_wdata, ls_rdata;
   logic [1:0]  ls_size;
   logic        ram_rw_cen_o, ram_rw_wen_o, ram_rw_ready_i;
   logic [63:0] ram_rw_addr_o, ram_rw_wdata_o, ram_rw_data_i;
   logic [7:0]  ram_rw_wmask_o;
   logic [2:0]  ram_rw_size_o;

   ram_rw_master #(.RR_ARB(0)) dut (
      .clock          (clock),
      .reset          (reset),
      .if_req_valid   (if_req_valid),
      .if_req_ready   (if_req_ready),
      .if_addr        (if_addr),
      .if_rsp_valid   (if_rsp_valid),
      .if_instr       (if_instr),
      .if_err         (if_err),
      .ls_req_valid   (ls_req_valid),
      .ls_req_ready   (ls_req_ready),
      .ls_we          (ls_we),
      .ls_addr        (ls_addr),
      .ls_size        (ls_size),
      .ls_unsigned    (ls_unsigned),
      .ls_wdata       (ls_wdata),
      .ls_rsp_valid   (ls_rsp_valid),
      .ls_rdata       (ls_rdata),
      .ls_err         (ls_err),
      .ram_rw_cen_o   (ram_rw_cen_o),
      .ram_rw_wen_o   (ram_rw_wen_o),
      .ram_rw_addr_o  (ram_rw_addr_o),
      .ram_rw_wdata_o (ram_rw_wdata_o),
      .ram_rw_wmask_o (ram_rw_wmask_o),
      .ram_rw_size_o  (ram_rw_size_o),
      .ram_rw_ready_i (ram_rw_ready_i),
      .ram_rw_data_i  (ram_rw_data_i)
   );

   typedef struct {
      logic [63:0] data;
      logic        err;
      int          due;
   } rsp_t;

   typedef struct {
      logic        wen;
      logic [63:0] addr;
      logic [7:0]  wmask;
      logic [63:0] wdata;
      logic [2:0]  size;
   } ram_t;

   rsp_t ls_q[$];
   rsp_t if_q[$];
   ram_t ram_q[$];
   logic [63:0] mem [logic [60:0]];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endfunction

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // RAM responder: ready with data one cycle after each cen.
   initial begin
      logic        pend;
      logic [63:0] pend_data, cur;
      logic [60:0] idx;
      pend = 1'b0;
      pend_data = '0;
      ram_rw_ready_i = 1'b0;
      ram_rw_data_i = '0;
      forever begin
         @(posedge clock);
         #1;
         ram_rw_ready_i = pend;
         ram_rw_data_i = pend ? pend_data : 64'd0;
         pend = 1'b0;
         if (ram_rw_cen_o) begin
            idx = ram_rw_addr_o[63:3];
            cur = mem.exists(idx) ? mem[idx] : 64'd0;
            if (ram_rw_wen_o) begin
               for (int i = 0; i < 8; i++)
                  if (ram_rw_wmask_o[i]) cur[8*i +: 8] = ram_rw_wdata_o[8*i +: 8];
               mem[idx] = cur;
            end
            pend = 1'b1;
            pend_data = cur;
         end
      end
   end

   // Monitor: compare every response and RAM access against the queues.
   initial begin
      rsp_t le, fe;
      ram_t re;
      forever begin
         @(negedge clock);
         if (ls_rsp_valid) begin
            if (ls_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL ls_unexpected: got ls_rsp_valid=1 required none");
            end else begin
               le = ls_q.pop_front();
               check("ls_rdata", ls_rdata, le.data);
               check("ls_err", 64'(ls_err), 64'(le.err));
               check("ls_latency", 64'(cyc), 64'(le.due));
            end
         end
         if (if_rsp_valid) begin
            if (if_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL if_unexpected: got if_rsp_valid=1 required none");
            end else begin
               fe = if_q.pop_front();
               check("if_instr", 64'(if_instr), fe.data);
               check("if_err", 64'(if_err), 64'(fe.err));
               check("if_latency", 64'(cyc), 64'(fe.due));
            end
         end
         if (ram_rw_cen_o) begin
            if (ram_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL ram_unexpected: got cen=1 addr=%h required no access",
                        ram_rw_addr_o);
            end else begin
               re = ram_q.pop_front();
               check("ram_wen", 64'(ram_rw_wen_o), 64'(re.wen));
               check("ram_addr", ram_rw_addr_o, re.addr);
               check("ram_wmask", 64'(ram_rw_wmask_o), 64'(re.wmask));
               check("ram_wdata", ram_rw_wdata_o, re.wdata);
               check("ram_size", 64'(ram_rw_size_o), 64'(re.size));
            end
         end
      end
   end

   task automatic ls_req(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata, input logic [7:0] exp_mask,
                         input logic [63:0] exp_wdata, input logic [63:0] exp_rdata,
                         input logic exp_err, input logic expect_rsp, output int acc);
      int n = 0;
      ls_req_valid = 1'b1; ls_we = we; ls_addr = addr; ls_size = size;
      ls_unsigned = uns; ls_wdata = wdata;
      @(negedge clock);
      while (!ls_req_ready) begin
         if (n >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL ls_accept_timeout: got ready=0 required ready within 100 cycles");
            break;
         end
         @(negedge clock);
         n++;
      end
      acc = cyc;
      if (!exp_err)
         ram_q.push_back('{wen: we, addr: addr, wmask: exp_mask, wdata: exp_wdata,
                           size: {1'b0, size}});
      if (expect_rsp)
         ls_q.push_back('{data: exp_rdata, err: exp_err, due: acc + (exp_err ? 1 : 3)});
      @(posedge clock);
      #1;
      ls_req_valid = 1'b0;
   endtask

   task automatic if_req(input logic [63:0] addr, input logic [31:0] exp_instr,
                         input logic exp_err, output int acc);
      int n = 0;
      if_req_valid = 1'b1; if_addr = addr;
      @(negedge clock);
      while (!if_req_ready) begin
         if (n >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL if_accept_timeout: got ready=0 required ready within 100 cycles");
            break;
         end
         @(negedge clock);
         n++;
      end
      acc = cyc;
      if (!exp_err)
         ram_q.push_back('{wen: 1'b0, addr: addr, wmask: 8'h00, wdata: 64'd0, size: 3'd2});
      if_q.push_back('{data: 64'(exp_instr), err: exp_err, due: acc + (exp_err ? 1 : 3)});
      @(posedge clock);
      #1;
      if_req_valid = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_ls_ready", 64'(ls_req_ready), 64'd0);
      check("rst_if_ready", 64'(if_req_ready), 64'd0);
      check("rst_cen", 64'(ram_rw_cen_o), 64'd0);
      check("rst_rsp", 64'({ls_rsp_valid, if_rsp_valid, ls_err, if_err}), 64'd0);
      check("rst_ls_rdata", ls_rdata, 64'd0);
   endtask

   localparam logic [63:0] Dw = 64'h1122334455667788;

   initial begin
      int a, b;
      reset = 1'b1;
      if_req_valid = 0; if_addr = '0;
      ls_req_valid = 0; ls_we = 0; ls_addr = '0; ls_size = '0; ls_unsigned = 0; ls_wdata = '0;
      mem[61'h10000000] = 64'hDEADBEEF_00000013;  // 0x80000000
      mem[61'h10000002] = 64'h00000000_80FF0000;  // 0x80000010
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_reset_outputs();
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("post_rst_ls_ready", 64'(ls_req_ready), 64'd1);
      check("post_rst_if_ready", 64'(if_req_ready), 64'd0);
      @(posedge clock);
      #1;

      if_req(64'h80000004, 32'hDEADBEEF, 1'b0, a);
      if_req(64'h80000000, 32'h00000013, 1'b0, a);
      if_req(64'h80000002, 32'h0, 1'b1, a);
      ls_req(0, 64'h80000013, 2'd0, 0, 0, 8'h00, 0, 64'hFFFFFFFFFFFFFF80, 0, 1, a);
      ls_req(0, 64'h80000013, 2'd0, 1, 0, 8'h00, 0, 64'h80, 0, 1, a);
      ls_req(0, 64'h80000012, 2'd0, 0, 0, 8'h00, 0, 64'hFFFFFFFFFFFFFFFF, 0, 1, a);
      ls_req(0, 64'h80000012, 2'd0, 1, 0, 8'h00, 0, 64'hFF, 0, 1, a);
      ls_req(0, 64'h80000012, 2'd1, 0, 0, 8'h00, 0, 64'hFFFFFFFFFFFF80FF, 0, 1, a);
      ls_req(0, 64'h80000010, 2'd2, 1, 0, 8'h00, 0, 64'h80FF0000, 0, 1, a);
      ls_req(0, 64'h80000010, 2'd2, 0, 0, 8'h00, 0, 64'hFFFFFFFF80FF0000, 0, 1, a);
      ls_req(1, 64'h80000010, 2'd3, 0, Dw, 8'hFF, Dw, 0, 0, 1, a);
      ls_req(0, 64'h80000010, 2'd3, 1, 0, 8'h00, 0, Dw, 0, 1, a);
      ls_req(1, 64'h80000006, 2'd1, 0, 64'hBEEF, 8'hC0, 64'hBEEF000000000000, 0, 0, 1, a);
      ls_req(0, 64'h80000006, 2'd1, 1, 0, 8'h00, 0, 64'hBEEF, 0, 1, a);
      ls_req(0, 64'h80000006, 2'd1, 0, 0, 8'h00, 0, 64'hFFFFFFFFFFFFBEEF, 0, 1, a);
      if_req(64'h80000004, 32'hBEEFBEEF, 1'b0, a);
      // Misaligned requests: immediate error, no RAM traffic, no write.
      ls_req(0, 64'h80000002, 2'd2, 0, 0, 8'h00, 0, 0, 1, 1, a);
      ls_req(0, 64'h80000004, 2'd3, 0, 0, 8'h00, 0, 0, 1, 1, a);
      ls_req(1, 64'h80000001, 2'd1, 0, 64'hAAAA, 8'h00, 0, 0, 1, 1, a);
      ls_req(0, 64'h80000001, 2'd0, 1, 0, 8'h00, 0, 64'h00, 0, 1, a);

      // Contention: data port first, fetch granted on the data response cycle.
      fork
         ls_req(0, 64'h80000010, 2'd3, 0, 0, 8'h00, 0, Dw, 0, 1, a);
         if_req(64'h80000000, 32'h00000013, 1'b0, b);
      join
      check("arb_fetch_accept_cycle", 64'(b), 64'(a + 3));

      // Reset while the load waits on the RAM: its response must vanish.
      ls_req(0, 64'h80000010, 2'd3, 0, 0, 8'h00, 0, Dw, 0, 0, a);
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check_reset_outputs();
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst2_ls_ready", 64'(ls_req_ready), 64'd1);
      repeat (5) @(posedge clock);
      #1;
      ls_req(0, 64'h80000010, 2'd3, 0, 0, 8'h00, 0, Dw, 0, 1, a);

      for (int i = 0; i < 50; i++) begin
         if (ls_q.size() == 0 && if_q.size() == 0 && ram_q.size() == 0) break;
         @(negedge clock);
      end
      repeat (3) @(negedge clock);
      check("ls_q_drained", 64'(ls_q.size()), 64'd0);
      check("if_q_drained", 64'(if_q.size()), 64'd0);
      check("ram_q_drained", 64'(ram_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
